fft_addr_gen: RTL and testbench

Address generator and stage/iteration sequencer for the radix-2 DIT FFT datapath. It turns the main controller's 2-bit addr_mode plus a step pulse into on-chip SRAM data addresses (A/B operands) and twiddle ROM indices. It keeps the butterfly and stage counters and reports iteration_strobe and stage_done back to the main controller. It sits between the main controller and the SRAM/twiddle ROM.

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_addr_gen_if.sv | 41 ++++
 rtl/fft_bfly_addr_calc.sv | 40 ++++
 rtl/fft_addr_gen.sv | 133 +++++++++++++
 tb/tb_fft_addr_gen.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared FFT sizing constants and address-mode encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_pkg;

    typedef enum logic [1:0] {
        ADDR_IDLE       = 2'b00,
        ADDR_LOAD_AB    = 2'b01,
        ADDR_TWIDDLE    = 2'b10,
        ADDR_WRITE_BACK = 2'b11
    } addr_mode_t;

    localparam int FFT_LOG2N = 4;
    localparam int FFT_N     = 1 << FFT_LOG2N;

endpackage

`default_nettype wire

// File: rtl/fft_addr_gen_if.sv
// ============================================================================
// Module   : fft_addr_gen_if
// Brief    : Controller <-> address generator bus (mode/step in, addresses out).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fft_addr_gen_if
    import fft_pkg::*;
#(
    parameter int LOG2N = FFT_LOG2N
) ();

    localparam int c_stage_w = $clog2(LOG2N) + 1;

    logic                 clear;
    addr_mode_t           addr_mode;
    logic                 advance;
    logic [LOG2N:0]       sram_addr;
    logic [LOG2N-2:0]     twiddle_addr;
    logic                 addr_valid;
    logic                 ab_sel;
    logic [c_stage_w-1:0] stage_num;
    logic                 iteration_strobe;
    logic                 stage_done;

    modport master (
        output clear, addr_mode, advance,
        input  sram_addr, twiddle_addr, addr_valid, ab_sel,
               stage_num, iteration_strobe, stage_done
    );

    modport slave (
        input  clear, addr_mode, advance,
        output sram_addr, twiddle_addr, addr_valid, ab_sel,
               stage_num, iteration_strobe, stage_done
    );

endinterface

`default_nettype wire

// File: rtl/fft_bfly_addr_calc.sv
// ============================================================================
// Module   : fft_bfly_addr_calc
// Brief    : Combinational (stage, butterfly) -> (A, B, twiddle index) mapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_bfly_addr_calc #(
    parameter int LOG2N   = 4,
    parameter int STAGE_W = $clog2(LOG2N) + 1
) (
    input  logic [STAGE_W-1:0] stage,
    input  logic [LOG2N-2:0]   bfly,
    output logic [LOG2N-1:0]   addr_a,
    output logic [LOG2N-1:0]   addr_b,
    output logic [LOG2N-2:0]   tw_idx
);

    localparam logic [LOG2N-2:0]   c_ones   = '1;
    localparam logic [LOG2N-1:0]   c_one    = LOG2N'(1);
    localparam logic [STAGE_W-1:0] c_tw_top = STAGE_W'(LOG2N - 1);

    logic [LOG2N-2:0] w_mask;
    logic [LOG2N-2:0] w_pos;
    logic [LOG2N-2:0] w_grp;
    logic [LOG2N-1:0] w_half;

    // pos and grp both fit in LOG2N-1 bits because b < N/2
    assign w_mask = ~(c_ones << stage);
    assign w_pos  = bfly & w_mask;
    assign w_grp  = bfly >> stage;
    assign w_half = c_one << stage;

    assign addr_a = ({w_grp, 1'b0} << stage) | {1'b0, w_pos};
    assign addr_b = addr_a + w_half;
    assign tw_idx = w_pos << (c_tw_top - stage);

endmodule

`default_nettype wire

// File: rtl/fft_addr_gen.sv
// ============================================================================
// Module   : fft_addr_gen
// Brief    : Radix-2 DIT FFT SRAM/twiddle address generator and stage sequencer.
//            Define FFT_ADDR_PINGPONG_EN for out-of-place ping-pong banking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = FFT_LOG2N
) (
    input  logic           clk,
    input  logic           n_rst,
    fft_addr_gen_if.slave  bus
);

    localparam int                   c_stage_w    = $clog2(LOG2N) + 1;
    localparam logic [c_stage_w-1:0] c_last_stage = c_stage_w'(LOG2N - 1);

    logic [c_stage_w-1:0] r_stage;
    logic [LOG2N-2:0]     r_bfly;
    logic                 r_phase;
    addr_mode_t           r_prev_mode;
    logic                 r_iter_strobe;
    logic                 r_stage_done;

    logic [c_stage_w-1:0] w_stage_nxt;
    logic [LOG2N-2:0]     w_bfly_nxt;
    logic                 w_phase_nxt;
    logic                 w_iter_nxt;
    logic                 w_done_nxt;

    logic                 w_phase;
    logic                 w_data_mode;
    logic                 w_bank;
    logic [LOG2N-1:0]     w_addr_a;
    logic [LOG2N-1:0]     w_addr_b;
    logic [LOG2N-2:0]     w_tw_idx;

    fft_bfly_addr_calc #(
        .LOG2N   (LOG2N),
        .STAGE_W (c_stage_w)
    ) u_calc (
        .stage  (r_stage),
        .bfly   (r_bfly),
        .addr_a (w_addr_a),
        .addr_b (w_addr_b),
        .tw_idx (w_tw_idx)
    );

    // A mode change abandons any half-finished A/B pair in the same cycle
    assign w_phase = (bus.addr_mode != r_prev_mode) ? 1'b0 : r_phase;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stage       <= '0;
            r_bfly        <= '0;
            r_phase       <= 1'b0;
            r_prev_mode   <= ADDR_IDLE;
            r_iter_strobe <= 1'b0;
            r_stage_done  <= 1'b0;
        end else begin
            r_stage       <= w_stage_nxt;
            r_bfly        <= w_bfly_nxt;
            r_phase       <= w_phase_nxt;
            r_prev_mode   <= bus.addr_mode;
            r_iter_strobe <= w_iter_nxt;
            r_stage_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_stage_nxt = r_stage;
        w_bfly_nxt  = r_bfly;
        w_phase_nxt = w_phase;
        w_iter_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        if (bus.clear) begin
            w_stage_nxt = '0;
            w_bfly_nxt  = '0;
            w_phase_nxt = 1'b0;
        end else if (bus.advance) begin
            unique case (bus.addr_mode)
                ADDR_LOAD_AB: w_phase_nxt = ~w_phase;
                ADDR_WRITE_BACK: begin
                    if (!w_phase) begin
                        w_phase_nxt = 1'b1;
                    end else begin
                        w_phase_nxt = 1'b0;
                        if (r_bfly == '1) begin
                            w_bfly_nxt = '0;
                            w_iter_nxt = 1'b1;
                            if (r_stage == c_last_stage) begin
                                w_stage_nxt = '0;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_stage_nxt = r_stage + c_stage_w'(1);
                            end
                        end else begin
                            w_bfly_nxt = r_bfly + (LOG2N-1)'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_data_mode = (bus.addr_mode == ADDR_LOAD_AB) ||
                         (bus.addr_mode == ADDR_WRITE_BACK);

`ifdef FFT_ADDR_PINGPONG_EN
    // Reads come from bank s[0], writes go to the opposite bank
    assign w_bank = (bus.addr_mode == ADDR_LOAD_AB)    ? r_stage[0]  :
                    (bus.addr_mode == ADDR_WRITE_BACK) ? ~r_stage[0] : 1'b0;
`else
    assign w_bank = 1'b0;
`endif

    assign bus.sram_addr        = w_data_mode ? {w_bank, (w_phase ? w_addr_b : w_addr_a)}
                                              : '0;
    assign bus.twiddle_addr     = (bus.addr_mode == ADDR_TWIDDLE) ? w_tw_idx : '0;
    assign bus.addr_valid       = (bus.addr_mode != ADDR_IDLE);
    assign bus.ab_sel           = w_phase;
    assign bus.stage_num        = r_stage;
    assign bus.iteration_strobe = r_iter_strobe;
    assign bus.stage_done       = r_stage_done;

endmodule

`default_nettype wire

// File: tb/tb_fft_addr_gen.sv
// ============================================================================
// Module   : tb_fft_addr_gen
// Brief    : Self-checking bench for fft_addr_gen (LOG2N=3) against an
//            arithmetic reference model; honours FFT_ADDR_PINGPONG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_addr_gen;
    import fft_pkg::*;

    localparam int LOG2N = 3;
    localparam int N     = 1 << LOG2N;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    always #5 clk = ~clk;

    fft_addr_gen_if #(.LOG2N(LOG2N)) bus ();

    fft_addr_gen #(.LOG2N(LOG2N)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: stage, butterfly, phase, last mode, pending pulses
    int m_s, m_b, m_p, m_prev, m_strobe, m_done;
    int strobe_seen, done_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s = 0; m_b = 0; m_p = 0; m_prev = 0; m_strobe = 0; m_done = 0;
    endtask

    task automatic check_outputs(input int mode);
        int eff_p, half, pos, grp, a, b, exp_lo, exp_msb, exp_tw;
        eff_p   = (mode != m_prev) ? 0 : m_p;
        half    = 1 << m_s;
        pos     = m_b % half;
        grp     = m_b / half;
        a       = grp * 2 * half + pos;
        b       = a + half;
        exp_lo  = (mode == 1 || mode == 3) ? (eff_p != 0 ? b : a) : 0;
        exp_msb = 0;
`ifdef FFT_ADDR_PINGPONG_EN
        if (mode == 1)      exp_msb = m_s % 2;
        else if (mode == 3) exp_msb = 1 - (m_s % 2);
`endif
        exp_tw  = (mode == 2) ? pos * (1 << (LOG2N - 1 - m_s)) : 0;
        chk("sram_addr",        32'(bus.sram_addr),        32'(exp_msb * N + exp_lo));
        chk("twiddle_addr",     32'(bus.twiddle_addr),     32'(exp_tw));
        chk("addr_valid",       32'(bus.addr_valid),       32'(mode != 0));
        chk("ab_sel",           32'(bus.ab_sel),           32'(eff_p));
        chk("stage_num",        32'(bus.stage_num),        32'(m_s));
        chk("iteration_strobe", 32'(bus.iteration_strobe), 32'(m_strobe));
        chk("stage_done",       32'(bus.stage_done),       32'(m_done));
    endtask

    task automatic model_step(input int mode, input bit adv, input bit clr);
        int eff_p;
        eff_p    = (mode != m_prev) ? 0 : m_p;
        m_strobe = 0;
        m_done   = 0;
        if (clr) begin
            m_s = 0; m_b = 0; m_p = 0;
        end else begin
            m_p = eff_p;
            if (adv && mode == 1) begin
                m_p = 1 - eff_p;
            end else if (adv && mode == 3) begin
                if (eff_p == 0) begin
                    m_p = 1;
                end else begin
                    m_p = 0;
                    if (m_b == N / 2 - 1) begin
                        m_b      = 0;
                        m_strobe = 1;
                        if (m_s == LOG2N - 1) begin
                            m_s    = 0;
                            m_done = 1;
                        end else begin
                            m_s = m_s + 1;
                        end
                    end else begin
                        m_b = m_b + 1;
                    end
                end
            end
        end
        m_prev = mode;
    endtask

    task automatic step(input int mode, input bit adv, input bit clr);
        bus.addr_mode = addr_mode_t'(mode[1:0]);
        bus.advance   = adv;
        bus.clear     = clr;
        #2;
        check_outputs(mode);
        if (bus.iteration_strobe === 1'b1) strobe_seen++;
        if (bus.stage_done === 1'b1) begin
            done_seen++;
            chk("done_with_strobe", 32'(bus.iteration_strobe), 32'd1);
        end
        @(posedge clk);
        model_step(mode, adv, clr);
        #1;
    endtask

    task automatic butterfly();
        step(1, 1'b1, 1'b0);
        step(1, 1'b1, 1'b0);
        step(2, 1'b1, 1'b0);
        step(3, 1'b1, 1'b0);
        step(3, 1'b1, 1'b0);
    endtask

    initial begin
        bus.clear     = 1'b0;
        bus.addr_mode = ADDR_IDLE;
        bus.advance   = 1'b0;
        model_reset();
        strobe_seen = 0;
        done_seen   = 0;

        // Reset state, held in reset across an edge
        @(posedge clk); #1;
        step(0, 1'b1, 1'b0);
        n_rst = 1'b1;
        step(0, 1'b0, 1'b0);

        // One butterfly at stage 0, then the rest of an 8-point transform
        strobe_seen = 0;
        done_seen   = 0;
        butterfly();
        for (int i = 1; i < 12; i++) butterfly();
        step(0, 1'b0, 1'b0);
        chk("full_run_strobes", 32'(strobe_seen), 32'd3);
        chk("full_run_done",    32'(done_seen),   32'd1);

        // Half-finished A/B pair abandoned by a mode change
        step(1, 1'b1, 1'b0);
        step(2, 1'b0, 1'b0);
        step(1, 1'b0, 1'b0);
        chk("abandon_is_a", 32'(bus.ab_sel), 32'd0);

        // clear on the wrapping B write-back suppresses the strobe
        for (int i = 0; i < 3; i++) butterfly();
        step(1, 1'b1, 1'b0);
        step(1, 1'b1, 1'b0);
        step(3, 1'b1, 1'b0);
        step(3, 1'b1, 1'b1);
        step(0, 1'b0, 1'b0);
        chk("clear_no_strobe", 32'(bus.iteration_strobe), 32'd0);

        // Asynchronous reset in the middle of stage 1
        for (int i = 0; i < 5; i++) butterfly();
        step(1, 1'b1, 1'b0);
        bus.addr_mode = ADDR_IDLE;
        bus.advance   = 1'b0;
        #3;
        n_rst = 1'b0;
        #1;
        chk("arst_stage",  32'(bus.stage_num),        32'd0);
        chk("arst_strobe", 32'(bus.iteration_strobe), 32'd0);
        chk("arst_done",   32'(bus.stage_done),       32'd0);
        chk("arst_sram",   32'(bus.sram_addr),        32'd0);
        chk("arst_absel",  32'(bus.ab_sel),           32'd0);
        model_reset();
        @(posedge clk); #1;
        n_rst = 1'b1;
        step(1, 1'b1, 1'b0);
        step(1, 1'b0, 1'b0);

        // Randomised traffic, weighted toward progress
        for (int i = 0; i < 800; i++) begin
            int mode;
            mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3))
                                               : int'($urandom_range(1, 3));
            step(mode, bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
